apu_frame_sequencer: RTL and testbench
======================================

// Module: apu_frame_sequencer
// PURPOSE
//  Frame counter/scheduler for the APU channel datapaths (pulse 1/2, triangle, noise).
//  Counts CPU-rate ticks and emits quarter-frame (envelope/linear counter) and half-frame
//  (length counter/sweep) strobes in 4-step or 5-step mode, as configured by $4017 writes.
//  Raises the frame IRQ, which is readable via $4015 bit 6. Sits beside the APU register file.
// PARAMETERS
//  CNT_W     16     width of tick counter
//  STEP1     7457   tick count of step 1
//  STEP2     14913  tick count of step 2
//  STEP3     22371  tick count of step 3
//  STEP4     29829  tick count of step 4 (end of sequence in 4-step mode)
//  STEP5     37281  tick count of step 5 (end of sequence in 5-step mode)
//  WR_DELAY  3      ticks from a $4017 write until the counter restarts
// PORTS
//  clk            in   1  APU system clock
//  rst            in   1  synchronous reset, active-high
//  cpu_ce         in   1  tick enable; one clk cycle high per CPU cycle
//  fc_wr          in   1  write strobe to $4017 (one clk cycle)
//  fc_data        in   8  write data; [7]=mode (1=5-step), [6]=irq_inhibit
//  status_rd      in   1  read strobe of $4015 (clears frame IRQ)
//  quarter_frame  out  1  1-clk strobe: clock envelopes and triangle linear counter
//  half_frame     out  1  1-clk strobe: clock length counters and sweeps
//  frame_irq      out  1  frame interrupt flag, level, active-high
//  mode_5step     out  1  current mode bit
// BEHAVIOUR
//  Reset (rst=1 at clk edge) sets cnt=0, mode=0, inhibit=0, frame_irq=0, strobes=0, pending=0.
//   Reset overrides fc_wr, status_rd and cpu_ce in the same cycle.
//  cnt advances only on cpu_ce. On each ce, the step is decoded from the pre-increment cnt
//   and the registered mode:
//   4-step: STEP1 QF | STEP2 QF+HF | STEP3 QF | STEP4 QF+HF, IRQ set if !inhibit, cnt<=0.
//   5-step: STEP1 QF | STEP2 QF+HF | STEP3 QF | STEP4 none | STEP5 QF+HF, cnt<=0. Never sets IRQ.
//   Other counts: cnt<=cnt+1.
//  Strobe latency: registered; high for exactly the one clk cycle after the matching ce.
//   Strobes are 0 in every other cycle, including ce cycles with no step match.
//  fc_wr: mode and inhibit load at that edge and are used from the next ce.
//   If fc_data[6]=1, frame_irq clears at the same edge.
//   Loads delay=WR_DELAY and sets pending=1. fc_wr is accepted with or without cpu_ce.
//  While pending: each ce decrements delay, and normal counting/step decode continues.
//   On the ce where delay==1: cnt<=0, pending<=0, and step decode for that ce is suppressed.
//   If mode=1, QF+HF also strobe (same 1-clk latency). If mode=0, no strobe.
//  A new fc_wr while pending restarts delay at WR_DELAY with the new mode/inhibit.
//   A write that shares a cycle with a ce applies its load; the decrement of that ce is lost.
//  status_rd clears frame_irq at the next edge. If an IRQ set coincides, the set wins (flag stays 1).
//   If fc_wr with inhibit=1 coincides with an IRQ set, the inhibit wins (cleared).
//  While inhibit=1, frame_irq cannot be set; a flag already set stays until status_rd or inhibit write.
//  cnt never exceeds STEP5. If cnt>STEP4 in 4-step mode after a mode change, cnt<=0 on the next ce,
//   with no strobe and no IRQ.
//  No combinational path from any input to any output.
// TESTING
//  1 Reset, ce every cycle, 4-step: QF at ticks 7457/14913/22371/29829, HF at 14913/29829;
//    frame_irq=1 after 29829; cnt wraps to 0.
//  2 Write fc_data=8'h80: after 3 ce, QF+HF strobe together; next QF at +7457; no STEP4 strobe;
//    QF+HF at STEP5; frame_irq stays 0 for 3 full sequences.
//  3 IRQ set, then status_rd=1 -> frame_irq=0 next clk; status_rd on the same edge as the
//    STEP4 set -> frame_irq=1.
//  4 IRQ pending, write 8'h40 -> frame_irq=0 next clk; no IRQ at the following STEP4.
//    Write 8'h00 -> IRQ returns at the next STEP4.
//  5 Write 8'h00, then 8'h80 one ce later -> a single restart, 3 ce after the second write,
//    with QF+HF; no restart at the first write's timing.
//  6 rst pulse at cnt=20000 with a pending write -> all outputs 0, cnt=0, first QF at tick 7457,
//    4-step mode.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides CPU ticks into quarter/half-frame strobes
// and raises the frame IRQ in 4-step mode.
module apu_frame_sequencer #(
    parameter int CNT_W    = 16,
    parameter int STEP1    = 7457,
    parameter int STEP2    = 14913,
    parameter int STEP3    = 22371,
    parameter int STEP4    = 29829,
    parameter int STEP5    = 37281,
    parameter int WR_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_ce,
    input  logic       fc_wr,
    input  logic [7:0] fc_data,
    input  logic       status_rd,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode_5step
);

    localparam int DLY_W = $clog2(WR_DELAY + 1);

    localparam logic [CNT_W-1:0] S1      = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2      = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3      = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4      = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S5      = CNT_W'(STEP5);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(WR_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             pend_q, pend_d;
    logic             mode_q, mode_d;
    logic             inh_q, inh_d;
    logic             irq_q, irq_d;
    logic             qf_q, qf_d;
    logic             hf_q, hf_d;
    logic             irq_set;

    logic unused_data;
    assign unused_data = ^fc_data[5:0];

    always_comb begin
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        inh_d   = inh_q;
        irq_d   = irq_q;
        qf_d    = 1'b0;
        hf_d    = 1'b0;
        irq_set = 1'b0;

        if (cpu_ce) begin
            if (pend_q && dly_q == DLY_ONE) begin
                // Delayed restart replaces this tick's step decode
                cnt_d  = '0;
                pend_d = 1'b0;
                qf_d   = mode_q;
                hf_d   = mode_q;
            end else begin
                if (pend_q) begin
                    dly_d = dly_q - DLY_ONE;
                end
                if (cnt_q == S1 || cnt_q == S3) begin
                    qf_d  = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                end else if (cnt_q == S2) begin
                    qf_d  = 1'b1;
                    hf_d  = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!mode_q && cnt_q == S4) begin
                    qf_d    = 1'b1;
                    hf_d    = 1'b1;
                    irq_set = !inh_q;
                    cnt_d   = '0;
                end else if (!mode_q && cnt_q > S4) begin
                    // Left past the 4-step end by a mode switch
                    cnt_d = '0;
                end else if (mode_q && cnt_q == S5) begin
                    qf_d  = 1'b1;
                    hf_d  = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q > S5) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end

        if (fc_wr) begin
            mode_d = fc_data[7];
            inh_d  = fc_data[6];
            dly_d  = DLY_INIT;
            pend_d = 1'b1;
        end

        if (status_rd) begin
            irq_d = 1'b0;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end
        if (fc_wr && fc_data[6]) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dly_q  <= '0;
            pend_q <= 1'b0;
            mode_q <= 1'b0;
            inh_q  <= 1'b0;
            irq_q  <= 1'b0;
            qf_q   <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dly_q  <= dly_d;
            pend_q <= pend_d;
            mode_q <= mode_d;
            inh_q  <= inh_d;
            irq_q  <= irq_d;
            qf_q   <= qf_d;
            hf_q   <= hf_d;
        end
    end

    assign quarter_frame = qf_q;
    assign half_frame    = hf_q;
    assign frame_irq     = irq_q;
    assign mode_5step    = mode_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer: one full-size instance for the
// real step timings, one short-count instance for the corner sequences.
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_ce = 1'b0;
    logic       fc_wr = 1'b0;
    logic [7:0] fc_data = 8'h00;
    logic       status_rd = 1'b0;

    logic qf_a, hf_a, irq_a, mode_a;
    logic qf_b, hf_b, irq_b, mode_b;

    always #5 clk = ~clk;

    apu_frame_sequencer u_full (
        .clk           (clk),
        .rst           (rst),
        .cpu_ce        (cpu_ce),
        .fc_wr         (fc_wr),
        .fc_data       (fc_data),
        .status_rd     (status_rd),
        .quarter_frame (qf_a),
        .half_frame    (hf_a),
        .frame_irq     (irq_a),
        .mode_5step    (mode_a)
    );

    apu_frame_sequencer #(
        .STEP1 (25),
        .STEP2 (51),
        .STEP3 (76),
        .STEP4 (103),
        .STEP5 (128)
    ) u_short (
        .clk           (clk),
        .rst           (rst),
        .cpu_ce        (cpu_ce),
        .fc_wr         (fc_wr),
        .fc_data       (fc_data),
        .status_rd     (status_rd),
        .quarter_frame (qf_b),
        .half_frame    (hf_b),
        .frame_irq     (irq_b),
        .mode_5step    (mode_b)
    );

    // One record: optional setup cycle, then ce ticks until the next strobe.
    typedef struct {
        string      name;
        bit         sel;
        bit         pre;
        bit         pre_ce;
        bit         pre_wr;
        logic [7:0] pre_data;
        bit         pre_rd;
        bit         pre_irq;
        int         n;
        bit         qf;
        bit         hf;
        bit         irq;
        bit         mode;
    } vec_t;

    vec_t tbl[$];
    int   ri = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m0, m1, m2, m3, m4, m5;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit ce, input bit wr, input logic [7:0] d,
                       input bit rd, input bit r);
        cpu_ce    = ce;
        fc_wr     = wr;
        fc_data   = d;
        status_rd = rd;
        rst       = r;
        @(posedge clk);
        #1;
        cpu_ce    = 1'b0;
        fc_wr     = 1'b0;
        status_rd = 1'b0;
        rst       = 1'b0;
    endtask

    function automatic logic [3:0] outs(input bit sel);
        if (sel) return {qf_b, hf_b, irq_b, mode_b};
        return {qf_a, hf_a, irq_a, mode_a};
    endfunction

    task automatic add(input string nm, input bit sel, input int n,
                       input bit qf, input bit hf, input bit irq,
                       input bit mode);
        vec_t v;
        v.name = nm;
        v.sel = sel;
        v.pre = 1'b0;
        v.pre_ce = 1'b0;
        v.pre_wr = 1'b0;
        v.pre_data = 8'h00;
        v.pre_rd = 1'b0;
        v.pre_irq = 1'b0;
        v.n = n;
        v.qf = qf;
        v.hf = hf;
        v.irq = irq;
        v.mode = mode;
        tbl.push_back(v);
    endtask

    task automatic add_pre(input string nm, input bit sel, input bit ce,
                           input bit wr, input logic [7:0] d, input bit rd,
                           input bit pirq, input int n, input bit qf,
                           input bit hf, input bit irq, input bit mode);
        vec_t v;
        v.name = nm;
        v.sel = sel;
        v.pre = 1'b1;
        v.pre_ce = ce;
        v.pre_wr = wr;
        v.pre_data = d;
        v.pre_rd = rd;
        v.pre_irq = pirq;
        v.n = n;
        v.qf = qf;
        v.hf = hf;
        v.irq = irq;
        v.mode = mode;
        tbl.push_back(v);
    endtask

    task automatic find_evt(input bit sel, input int lim, output int n,
                            output logic [3:0] o);
        bit hit;
        n = 0;
        o = '0;
        hit = 1'b0;
        for (int i = 1; i <= lim && !hit; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            o = outs(sel);
            if (o[3] || o[2]) begin
                n = i;
                hit = 1'b1;
            end
        end
    endtask

    task automatic run_rows(input int hi);
        vec_t       v;
        int         n;
        logic [3:0] o;
        while (ri < hi) begin
            v = tbl[ri];
            if (v.pre) begin
                cyc(v.pre_ce, v.pre_wr, v.pre_data, v.pre_rd, 1'b0);
                o = outs(v.sel);
                chk({v.name, "/pre_irq"}, 32'(o[1]), 32'(v.pre_irq));
            end
            find_evt(v.sel, v.n + 16, n, o);
            chk({v.name, "/ticks"}, n, v.n);
            chk({v.name, "/qf"}, 32'(o[3]), 32'(v.qf));
            chk({v.name, "/hf"}, 32'(o[2]), 32'(v.hf));
            chk({v.name, "/irq"}, 32'(o[1]), 32'(v.irq));
            chk({v.name, "/mode"}, 32'(o[0]), 32'(v.mode));
            ri++;
        end
    endtask

    task automatic quiet(input bit sel, input int k, input string nm);
        int         s;
        logic [3:0] o;
        s = 0;
        for (int i = 0; i < k; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            o = outs(sel);
            if (o[3] || o[2]) s++;
        end
        chk(nm, s, 0);
    endtask

    task automatic chk_zero(input bit sel, input string nm);
        logic [3:0] o;
        o = outs(sel);
        chk({nm, "/qf"}, 32'(o[3]), 0);
        chk({nm, "/hf"}, 32'(o[2]), 0);
        chk({nm, "/irq"}, 32'(o[1]), 0);
        chk({nm, "/mode"}, 32'(o[0]), 0);
    endtask

    task automatic reset_all();
        cyc(1'b1, 1'b1, 8'hC0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 8'hC0, 1'b1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] o;

        add("t1_s1", 0, 7458, 1, 0, 0, 0);
        add("t1_s2", 0, 7456, 1, 1, 0, 0);
        add("t1_s3", 0, 7458, 1, 0, 0, 0);
        add("t1_s4", 0, 7458, 1, 1, 1, 0);
        add("t1_wrap", 0, 7458, 1, 0, 1, 0);
        m0 = tbl.size();

        add("b_s1", 1, 26, 1, 0, 0, 0);
        add("b_s2", 1, 26, 1, 1, 0, 0);
        add("b_s3", 1, 25, 1, 0, 0, 0);
        m1 = tbl.size();

        add("re_s1", 1, 26, 1, 0, 0, 0);
        add("re_s2", 1, 26, 1, 1, 0, 0);
        add("re_s3", 1, 25, 1, 0, 0, 0);
        add("re_s4", 1, 27, 1, 1, 1, 0);
        add_pre("t4_inh", 1, 0, 1, 8'h40, 0, 0, 29, 1, 0, 0, 0);
        add("t4_s2", 1, 26, 1, 1, 0, 0);
        add("t4_s3", 1, 25, 1, 0, 0, 0);
        add("t4_s4", 1, 27, 1, 1, 0, 0);
        add_pre("t4_uninh", 1, 0, 1, 8'h00, 0, 0, 29, 1, 0, 0, 0);
        add("t4_s2b", 1, 26, 1, 1, 0, 0);
        add("t4_s3b", 1, 25, 1, 0, 0, 0);
        add("t4_s4b", 1, 27, 1, 1, 1, 0);
        add_pre("t2_wr", 1, 0, 1, 8'h80, 1, 0, 3, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            add("t2_s1", 1, 26, 1, 0, 0, 1);
            add("t2_s2", 1, 26, 1, 1, 0, 1);
            add("t2_s3", 1, 25, 1, 0, 0, 1);
            add("t2_s5", 1, 52, 1, 1, 0, 1);
        end
        m2 = tbl.size();

        add_pre("t5_second", 1, 0, 1, 8'h80, 0, 0, 3, 1, 1, 0, 1);
        add_pre("wr_on_ce", 1, 1, 1, 8'h80, 0, 0, 3, 1, 1, 0, 1);
        add("mc_s1", 1, 26, 1, 0, 0, 1);
        add("mc_s2", 1, 26, 1, 1, 0, 1);
        add("mc_s3", 1, 25, 1, 0, 0, 1);
        m3 = tbl.size();

        add_pre("mc_to4", 1, 0, 1, 8'h00, 0, 0, 1, 1, 1, 1, 0);
        add("mc_restart", 1, 28, 1, 0, 1, 0);
        m4 = tbl.size();

        add("t6_s1", 1, 26, 1, 0, 0, 0);
        add("t6_s2", 1, 26, 1, 1, 0, 0);
        m5 = tbl.size();

        reset_all();
        chk_zero(0, "rst_full");
        chk_zero(1, "rst_short");
        run_rows(m0);

        reset_all();
        chk_zero(1, "rst2_short");
        run_rows(m1);

        // status_rd on the same edge as the STEP4 set: set wins
        quiet(1, 26, "t3_quiet");
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        o = outs(1);
        chk("t3_rd_vs_set/qf", 32'(o[3]), 1);
        chk("t3_rd_vs_set/hf", 32'(o[2]), 1);
        chk("t3_rd_vs_set/irq", 32'(o[1]), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        o = outs(1);
        chk("t3_rd_clear/irq", 32'(o[1]), 0);
        run_rows(m2);

        // First write is superseded by a second one a tick later
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_rows(m3);

        // Sitting exactly on STEP4 while switching to 4-step mode
        quiet(1, 26, "mc_quiet");
        run_rows(m4);

        // Reset mid-count with a write pending
        cyc(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hC0, 1'b1, 1'b1);
        chk_zero(1, "t6_rst");
        run_rows(m5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
